// File: rtl/mem_port_bridge.sv
// Data-memory port bridge: turns a memory-stage access into a req/ack bus
// cycle with stall, byte lanes, load extension and error reporting.
module mem_port_bridge #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                MEM_Req,
  input  logic                MEM_Cst_R_W,
  input  logic [2:0]          MEM_Cst_Size,
  input  logic [ADDR_W-1:0]   MEM_Address,
  input  logic [63:0]         MEM_Store_Data,
  output logic                MEM_Stall,
  output logic                MEM_Done,
  output logic                MEM_Err,
  output logic [63:0]         MEM_Load_Data,
  output logic                BUS_Req,
  output logic                BUS_We,
  output logic [ADDR_W-1:0]   BUS_Addr,
  output logic [DATA_W/8-1:0] BUS_Strb,
  output logic [DATA_W-1:0]   BUS_WData,
  input  logic                BUS_Ack,
  input  logic [DATA_W-1:0]   BUS_RData
);

  localparam int SW = DATA_W / 8;
  localparam int OW = $clog2(SW);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            r_state;
  logic [OW-1:0]     r_off;
  logic [2:0]        r_size;
  logic [15:0]       r_cnt;
  logic              r_req;
  logic              r_we;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [SW-1:0]     r_strb;
  logic [DATA_W-1:0] r_wdata;
  logic [63:0]       r_load;

  logic [OW-1:0]     w_off;
  logic              w_misal;
  logic              w_ill;
  logic [7:0]        w_mask8;
  logic [SW-1:0]     w_strb;
  logic [DATA_W-1:0] w_wdata;
  logic [63:0]       w_sh;
  logic [63:0]       w_load;
  logic [16:0]       w_cnt_nx;

  assign w_off    = MEM_Address[OW-1:0];
  assign w_strb   = SW'(w_mask8) << w_off;
  assign w_wdata  = MEM_Store_Data[DATA_W-1:0] << {w_off, 3'b000};
  assign w_sh     = 64'(BUS_RData >> {r_off, 3'b000});
  assign w_cnt_nx = {1'b0, r_cnt} + 17'd1;

  // Doubleword sizes have no home on a 32-bit bus
  assign w_ill = (MEM_Cst_Size == 3'b111) ||
                 ((DATA_W == 32) &&
                  (MEM_Cst_Size == 3'b011 || MEM_Cst_Size == 3'b110));

  always_comb begin
    w_misal = 1'b0;
    w_mask8 = 8'h01;
    case (MEM_Cst_Size[1:0])
      2'd1: begin w_misal = MEM_Address[0];    w_mask8 = 8'h03; end
      2'd2: begin w_misal = |MEM_Address[1:0]; w_mask8 = 8'h0F; end
      2'd3: begin w_misal = |MEM_Address[2:0]; w_mask8 = 8'hFF; end
      default: ;
    endcase
  end

  always_comb begin
    w_load = '0;
    case (r_size)
      3'b000: w_load = {{56{w_sh[7]}},  w_sh[7:0]};
      3'b001: w_load = {{48{w_sh[15]}}, w_sh[15:0]};
      3'b010: w_load = {{32{w_sh[31]}}, w_sh[31:0]};
      3'b011: w_load = w_sh;
      3'b100: w_load = {56'd0, w_sh[7:0]};
      3'b101: w_load = {48'd0, w_sh[15:0]};
      3'b110: w_load = {32'd0, w_sh[31:0]};
      default: w_load = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_off   <= '0;
      r_size  <= '0;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_strb  <= '0;
      r_wdata <= '0;
      r_load  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (MEM_Req) begin
          r_off  <= w_off;
          r_size <= MEM_Cst_Size;
          if (w_ill || w_misal) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_load  <= '0;
            r_state <= RESP;
          end else begin
            r_addr  <= {MEM_Address[ADDR_W-1:OW], {OW{1'b0}}};
            r_we    <= MEM_Cst_R_W;
            r_strb  <= MEM_Cst_R_W ? w_strb : '0;
            r_wdata <= w_wdata;
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: if (BUS_Ack) begin
          r_req   <= 1'b0;
          r_load  <= r_we ? '0 : w_load;
          r_done  <= 1'b1;
          r_state <= RESP;
        end else if (w_cnt_nx == 17'(TIMEOUT)) begin
          r_req   <= 1'b0;
          r_err   <= 1'b1;
          r_load  <= '0;
          r_done  <= 1'b1;
          r_state <= RESP;
        end else begin
          r_cnt <= w_cnt_nx[15:0];
        end
        RESP: begin
          r_err   <= 1'b0;
          r_load  <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated by RESET so the stall drops with the asynchronous reset
  assign MEM_Stall = !RESET &&
                     ((r_state == IDLE && MEM_Req) || r_state == BUSY);

  assign MEM_Done      = r_done;
  assign MEM_Err       = r_err;
  assign MEM_Load_Data = r_load;
  assign BUS_Req       = r_req;
  assign BUS_We        = r_we;
  assign BUS_Addr      = r_addr;
  assign BUS_Strb      = r_strb;
  assign BUS_WData     = r_wdata;

endmodule

// File: tb/tb_mem_port_bridge.sv
// Directed bench for mem_port_bridge: 64-bit port with a short timeout
// plus a 32-bit port for size legality and lane placement.
module tb_mem_port_bridge;

  logic        CLK;
  logic        RESET;
  logic        req, rw, ack;
  logic [2:0]  size;
  logic [63:0] addr, sdata, rdata;
  logic        stall, done, err, breq, bwe;
  logic [63:0] ld, baddr, bwdata;
  logic [7:0]  bstrb;

  logic        req32, ack32;
  logic [31:0] rdata32;
  logic        stall32, done32, err32, breq32, bwe32;
  logic [63:0] ld32, baddr32;
  logic [3:0]  bstrb32;
  logic [31:0] bwdata32;

  int checks = 0;
  int errors = 0;

  mem_port_bridge #(.DATA_W(64), .ADDR_W(64), .TIMEOUT(4)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_Req(req), .MEM_Cst_R_W(rw), .MEM_Cst_Size(size),
    .MEM_Address(addr), .MEM_Store_Data(sdata),
    .MEM_Stall(stall), .MEM_Done(done), .MEM_Err(err),
    .MEM_Load_Data(ld),
    .BUS_Req(breq), .BUS_We(bwe), .BUS_Addr(baddr),
    .BUS_Strb(bstrb), .BUS_WData(bwdata),
    .BUS_Ack(ack), .BUS_RData(rdata)
  );

  mem_port_bridge #(.DATA_W(32), .ADDR_W(64), .TIMEOUT(4)) u_dut32 (
    .CLK(CLK), .RESET(RESET),
    .MEM_Req(req32), .MEM_Cst_R_W(rw), .MEM_Cst_Size(size),
    .MEM_Address(addr), .MEM_Store_Data(sdata),
    .MEM_Stall(stall32), .MEM_Done(done32), .MEM_Err(err32),
    .MEM_Load_Data(ld32),
    .BUS_Req(breq32), .BUS_We(bwe32), .BUS_Addr(baddr32),
    .BUS_Strb(bstrb32), .BUS_WData(bwdata32),
    .BUS_Ack(ack32), .BUS_RData(rdata32)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          lat, ns, nb;
  logic [63:0] ld_o, a_o, wd_o;
  logic [7:0]  s_o;
  logic        e_o, we_o;

  // ack_cyc: BUSY cycle (1 = first) in which ack is driven; 0 = never
  task automatic access(input logic w, input logic [2:0] sz,
                        input logic [63:0] a, d, r, input int ack_cyc);
    @(posedge CLK); #1;
    req = 1'b1; rw = w; size = sz; addr = a; sdata = d; rdata = r;
    ack = 1'b0;
    lat = -1; ns = 0; nb = 0;
    ld_o = '0; e_o = 1'b0; a_o = '0; wd_o = '0; s_o = '0; we_o = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (stall) ns++;
      if (breq) nb++;
      if (k == 1) begin
        a_o = baddr; wd_o = bwdata; s_o = bstrb; we_o = bwe;
      end
      if (done) begin
        lat = k; ld_o = ld; e_o = err;
        break;
      end
      @(posedge CLK); #1;
      ack = (k + 1 == ack_cyc);
    end
    ack = 1'b0;
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    req = 1'b0; req32 = 1'b0; ack = 1'b0; ack32 = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    req = 0; rw = 0; ack = 0; size = 0; addr = 0; sdata = 0; rdata = 0;
    req32 = 0; ack32 = 0; rdata32 = 0;
    #3;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_err",   64'(err),   64'd0);
    chk("rst_ld",    ld,         64'd0);
    chk("rst_breq",  64'(breq),  64'd0);
    chk("rst_addr",  baddr,      64'd0);
    chk("rst_strb",  64'(bstrb), 64'd0);
    chk("rst_wdata", bwdata,     64'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    idle();

    access(1'b0, 3'b010, 64'h1004, 64'h0, 64'h80000000_11111111, 1);
    chk("lw_lat",  64'(lat),  64'd2);
    chk("lw_addr", a_o,       64'h1000);
    chk("lw_strb", 64'(s_o),  64'h00);
    chk("lw_we",   64'(we_o), 64'd0);
    chk("lw_data", ld_o,      64'hFFFFFFFF_80000000);
    chk("lw_err",  64'(e_o),  64'd0);
    chk("lw_stall", 64'(ns),  64'd2);
    idle();
    chk("lw_done_pulse", 64'(done), 64'd0);

    access(1'b1, 3'b001, 64'h2006, 64'hBEEF, 64'h0, 4);
    chk("sh_we",    64'(we_o), 64'd1);
    chk("sh_strb",  64'(s_o),  64'hC0);
    chk("sh_wdata", wd_o,      64'hBEEF0000_00000000);
    chk("sh_stall", 64'(ns),   64'd5);
    chk("sh_lat",   64'(lat),  64'd5);
    chk("sh_ld",    ld_o,      64'd0);
    chk("sh_err",   64'(e_o),  64'd0);
    idle();

    access(1'b0, 3'b101, 64'h3003, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    chk("mis_lat",  64'(lat), 64'd1);
    chk("mis_err",  64'(e_o), 64'd1);
    chk("mis_breq", 64'(nb),  64'd0);
    chk("mis_ld",   ld_o,     64'd0);
    idle();

    access(1'b0, 3'b111, 64'h3000, 64'h0, 64'hFFFF, 1);
    chk("ill_lat",  64'(lat), 64'd1);
    chk("ill_err",  64'(e_o), 64'd1);
    chk("ill_breq", 64'(nb),  64'd0);
    idle();

    access(1'b0, 3'b010, 64'h5000, 64'h0, 64'h1234, 0);
    chk("to_breq", 64'(nb),  64'd4);
    chk("to_lat",  64'(lat), 64'd5);
    chk("to_err",  64'(e_o), 64'd1);
    chk("to_ld",   ld_o,     64'd0);
    idle();

    access(1'b0, 3'b011, 64'h5008, 64'h0, 64'h01234567_89ABCDEF, 4);
    chk("ack4_breq", 64'(nb),  64'd4);
    chk("ack4_lat",  64'(lat), 64'd5);
    chk("ack4_err",  64'(e_o), 64'd0);
    chk("ack4_ld",   ld_o,     64'h01234567_89ABCDEF);
    idle();

    access(1'b0, 3'b000, 64'h6007, 64'h0, 64'h80AABBCC_DDEEFF11, 2);
    chk("lb_ld",  ld_o,     64'hFFFFFFFF_FFFFFF80);
    chk("lb_lat", 64'(lat), 64'd3);
    idle();

    access(1'b0, 3'b100, 64'h4001, 64'h0, 64'h00000000_00009C55, 1);
    chk("b2b_lbu", ld_o, 64'h9C);
    access(1'b1, 3'b011, 64'h4008, 64'h11223344_55667788, 64'h0, 1);
    chk("b2b_lat",   64'(lat), 64'd2);
    chk("b2b_addr",  a_o,      64'h4008);
    chk("b2b_strb",  64'(s_o), 64'hFF);
    chk("b2b_wdata", wd_o,     64'h11223344_55667788);
    chk("b2b_err",   64'(e_o), 64'd0);
    idle();

    @(posedge CLK); #1;
    ack = 1'b1;
    @(negedge CLK);
    chk("stray_breq", 64'(breq), 64'd0);
    @(posedge CLK); #1;
    ack = 1'b0;
    @(negedge CLK);
    chk("stray_done", 64'(done), 64'd0);

    @(posedge CLK); #1;
    rw = 1'b0; size = 3'b011; addr = 64'h7000; req32 = 1'b1;
    @(negedge CLK);
    chk("d32_stall", 64'(stall32), 64'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("d32_done", 64'(done32), 64'd1);
    chk("d32_err",  64'(err32),  64'd1);
    chk("d32_breq", 64'(breq32), 64'd0);
    @(posedge CLK); #1;
    rw = 1'b1; size = 3'b000; addr = 64'h7003; sdata = 64'hAB;
    @(posedge CLK); #1;
    ack32 = 1'b1;
    @(negedge CLK);
    chk("sb32_breq",  64'(breq32),   64'd1);
    chk("sb32_strb",  64'(bstrb32),  64'h8);
    chk("sb32_wdata", 64'(bwdata32), 64'hAB000000);
    chk("sb32_addr",  baddr32,       64'h7000);
    @(posedge CLK); #1;
    ack32 = 1'b0;
    @(negedge CLK);
    chk("sb32_done", 64'(done32), 64'd1);
    chk("sb32_err",  64'(err32),  64'd0);
    idle();

    @(posedge CLK); #1;
    req = 1'b1; rw = 1'b0; size = 3'b010; addr = 64'h8000; ack = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rb_breq_pre", 64'(breq), 64'd1);
    #2 RESET = 1'b1;
    #1;
    chk("rb_breq",  64'(breq),  64'd0);
    chk("rb_stall", 64'(stall), 64'd0);
    chk("rb_done",  64'(done),  64'd0);
    @(posedge CLK); #1;
    RESET = 1'b0; req = 1'b0;
    access(1'b0, 3'b010, 64'h1004, 64'h0, 64'h80000000_11111111, 1);
    chk("rb_fresh_lat", 64'(lat), 64'd2);
    chk("rb_fresh_ld",  ld_o,     64'hFFFFFFFF_80000000);
    chk("rb_fresh_err", 64'(e_o), 64'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
